// File: rtl/muldiv_if.sv
// ----------------------------------------------------------------------------
// muldiv_if
// Handshake and data bundle between the execute stage and the multiply/divide
// unit.
//   master : execute stage; drives start/op_div/op_signed/a/b/cancel and
//            observes stall/done/hi_out/lo_out
//   slave  : muldiv_unit; the opposite directions
// ----------------------------------------------------------------------------
interface muldiv_if;
    logic        start;
    logic        op_div;
    logic        op_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        stall;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output start, op_div, op_signed, a, b, cancel,
        input  stall, done, hi_out, lo_out
    );

    modport slave (
        input  start, op_div, op_signed, a, b, cancel,
        output stall, done, hi_out, lo_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
// 32-bit multiply / divide unit for the HI/LO register pair.
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : muldiv_if.slave
//          start/op_div/op_signed/a/b : operation request from execute stage
//          cancel                     : execute-stage flush, aborts in-flight op
//          stall                      : holds F/D/E while an op is running
//          done                       : one-cycle pulse, hi_out/lo_out valid
//          hi_out/lo_out              : product[63:32]/[31:0] or rem/quotient
// Multiply takes one cycle in MUL; divide is restoring radix-2 on operand
// magnitudes over 32 DIV cycles with the sign fix-up folded into the last one.
// ----------------------------------------------------------------------------
module muldiv_unit (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    // For multiply: raw operands. For divide: opa holds the dividend magnitude
    // that shifts left while quotient bits enter at its LSB; opb holds the
    // divisor magnitude.
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        sgn_q, sgn_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        bzero_q, bzero_d;
    logic        done_q, done_d;

    logic signed [65:0] prod_s;
    logic [32:0] rem_shift_s;
    logic [33:0] diff_s;
    logic        fits_s;
    logic [31:0] rem_next_s;
    logic [31:0] quo_next_s;
    logic        stall_s;

    // Two's-complement negate when cond is set.
    function automatic logic [31:0] neg_if(input logic cond, input logic [31:0] v);
        logic [31:0] r;
        if (cond) begin
            r = 32'd0 - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Product and one restoring-division step computed from the latched state.
    always_comb begin
        // Sign-extend to 33 bits only for signed ops; unsigned zero-extends.
        prod_s      = $signed({opa_q[31] & sgn_q, opa_q}) * $signed({opb_q[31] & sgn_q, opb_q});
        rem_shift_s = {rem_q, opa_q[31]};
        diff_s      = {1'b0, rem_shift_s} - {2'b00, opb_q};
        fits_s      = ~diff_s[33];
        // Either branch is below the divisor, so 32 bits always suffice.
        if (fits_s) begin
            rem_next_s = diff_s[31:0];
        end else begin
            rem_next_s = rem_shift_s[31:0];
        end
        quo_next_s  = {opa_q[30:0], fits_s};
    end

    // Next-state and datapath register update.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        bzero_d = bzero_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.cancel) begin
                    sgn_d = bus.op_signed;
                    cnt_d = 6'd0;
                    rem_d = 32'd0;
                    if (bus.op_div) begin
                        opa_d   = neg_if(bus.op_signed & bus.a[31], bus.a);
                        opb_d   = neg_if(bus.op_signed & bus.b[31], bus.b);
                        qneg_d  = bus.op_signed & (bus.a[31] ^ bus.b[31]);
                        rneg_d  = bus.op_signed & bus.a[31];
                        bzero_d = (bus.b == 32'd0);
                        state_d = DIV;
                    end else begin
                        opa_d   = bus.a;
                        opb_d   = bus.b;
                        state_d = MUL;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                if (bus.cancel) begin
                    state_d = IDLE;
                end else begin
                    hi_d    = prod_s[63:32];
                    lo_d    = prod_s[31:0];
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DIV: begin
                if (bus.cancel) begin
                    cnt_d   = 6'd0;
                    state_d = IDLE;
                end else begin
                    opa_d = quo_next_s;
                    rem_d = rem_next_s;
                    if (cnt_q == 6'd31) begin
                        cnt_d = 6'd0;
                        // Divide by zero yields all-ones quotient and the
                        // dividend as remainder regardless of signedness.
                        hi_d  = neg_if(rneg_q, rem_next_s);
                        if (bzero_q) begin
                            lo_d = 32'hFFFF_FFFF;
                        end else begin
                            lo_d = neg_if(qneg_q, quo_next_s);
                        end
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + 6'd1;
                        state_d = DIV;
                    end
                end
            end
            DONE: begin
                // The stalled instruction is still in E; its start is ignored.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            rem_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            cnt_q   <= 6'd0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            bzero_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            bzero_q <= bzero_d;
            done_q  <= done_d;
        end
    end

    // Stall must cover the acceptance cycle, so it is combinational.
    always_comb begin
        if (rst) begin
            stall_s = 1'b0;
        end else begin
            stall_s = (state_q == IDLE && bus.start && !bus.cancel) ||
                      (state_q == MUL) || (state_q == DIV);
        end
    end

    assign bus.stall  = stall_s;
    // A flush in the DONE cycle suppresses the HILO write.
    assign bus.done   = done_q & ~bus.cancel;
    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed vectors for muldiv_unit. Each issued op pushes its expected HI/LO
// and done cycle into a queue; a negedge monitor pops and compares on every
// done pulse and flags any done with nothing expected.
// ----------------------------------------------------------------------------
module tb_muldiv_unit;
    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          at;
    } exp_t;

    exp_t sb_q[$];

    muldiv_if bus ();

    muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle number of the current clock period.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result_hi", 64'(bus.hi_out), 64'(e.hi));
                chk("result_lo", 64'(bus.lo_out), 64'(e.lo));
                chk("done_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current cycle and follow it through DONE.
    task automatic run_op(input logic dv, input logic sg, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] eh,
                          input logic [31:0] el, input logic hold, input logic kill);
        int lat;
        int n;
        int t;
        lat = dv ? 33 : 2;
        t   = cyc;
        bus.op_div    = dv;
        bus.op_signed = sg;
        bus.a         = av;
        bus.b         = bv;
        bus.start     = 1'b1;
        #1;
        chk("stall_accept", 64'(bus.stall), 64'(1'b1));
        if (!kill) begin
            sb_q.push_back('{eh, el, t + lat});
        end
        step();
        if (!hold) begin
            bus.start = 1'b0;
        end
        n = 1;
        while (bus.stall === 1'b1 && n < 40) begin
            n++;
            step();
        end
        chk("stall_cycles", 64'(n), 64'(lat));
        if (kill) begin
            bus.cancel = 1'b1;
            #1;
            chk("done_killed", 64'(bus.done), 64'(1'b0));
        end
        step();
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        #1;
        chk("result_hold", {bus.hi_out, bus.lo_out}, {eh, el});
    endtask

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Directed stimulus.
    initial begin
        cyc           = 0;
        n_cmp         = 0;
        n_bad         = 0;
        rst           = 1'b1;
        bus.start     = 1'b1;
        bus.op_div    = 1'b0;
        bus.op_signed = 1'b0;
        bus.a         = 32'd1;
        bus.b         = 32'd1;
        bus.cancel    = 1'b0;
        step();
        chk("stall_in_reset", 64'(bus.stall), 64'(1'b0));
        step();
        chk("reset_done", 64'(bus.done), 64'(1'b0));
        chk("reset_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        #1;
        chk("idle_stall", 64'(bus.stall), 64'(1'b0));

        // Multiplies (back-to-back with each other).
        run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
        run_op(1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b0);
        run_op(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_op(1'b0, 1'b0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0);

        // Divides.
        run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op(1'b1, 1'b0, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 1'b0);
        run_op(1'b1, 1'b0, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_op(1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(1'b1, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0, 1'b0);

        // start held through DONE: exactly one done.
        run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op(1'b0, 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1, 1'b0);

        // Cancel in DONE: no done pulse.
        run_op(1'b0, 1'b0, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0, 1'b1);

        // Cancel with start in IDLE: not accepted.
        bus.op_div = 1'b0;
        bus.start  = 1'b1;
        bus.cancel = 1'b1;
        #1;
        chk("stall_start_cancel", 64'(bus.stall), 64'(1'b0));
        step();
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        #1;
        chk("not_accepted", 64'(bus.stall), 64'(1'b0));
        repeat (4) step();

        // Divide cancelled at t+10, then MULTU 3*4 at t+11.
        bus.op_div    = 1'b1;
        bus.op_signed = 1'b1;
        bus.a         = 32'd100;
        bus.b         = 32'd3;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (9) step();
        chk("stall_before_cancel", 64'(bus.stall), 64'(1'b1));
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        #1;
        chk("stall_after_cancel", 64'(bus.stall), 64'(1'b0));
        run_op(1'b0, 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0);

        // Reset at t+5 of a divide.
        bus.op_div    = 1'b1;
        bus.op_signed = 1'b0;
        bus.a         = 32'd1000;
        bus.b         = 32'd10;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        rst       = 1'b1;
        bus.start = 1'b1;
        #1;
        chk("stall_reset_mid", 64'(bus.stall), 64'(1'b0));
        step();
        rst       = 1'b0;
        bus.start = 1'b0;
        #1;
        chk("stall_after_reset", 64'(bus.stall), 64'(1'b0));
        chk("hilo_after_reset", {bus.hi_out, bus.lo_out}, 64'd0);
        repeat (40) step();

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
